// File: rtl/os_scale_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : os_scale_stage_pkg                                     |
// | Description : Config-bus address map, reset-time config values and   |
// |               config-op decode shared by the os_scale_stage slice.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package os_scale_stage_pkg;

  // Config bus endpoint addresses
  localparam int OSC_OS_ADDR  = 'h0030;
  localparam int OSC_EN_ADDR  = 'h0031;
  localparam int OSC_CLR_RQST = 'h0032;

  // Per-channel config values loaded by reset
  localparam int OSC_OS_INIT = 0;
  localparam int OSC_EN_INIT = 1;

  typedef enum logic [1:0] {
    CFG_NONE = 2'd0,
    CFG_OS   = 2'd1,
    CFG_EN   = 2'd2,
    CFG_CLR  = 2'd3
  } cfg_op_e;

  // Map a config-bus address onto the operation this stage performs
  function automatic cfg_op_e decode_cfg(input int unsigned addr);
    cfg_op_e op;
    op = CFG_NONE;
    if (addr == OSC_OS_ADDR)       op = CFG_OS;
    else if (addr == OSC_EN_ADDR)  op = CFG_EN;
    else if (addr == OSC_CLR_RQST) op = CFG_CLR;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/os_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : os_round_sat                                           |
// | Description : Combinational divide-by-2^os with round-half-up,       |
// |               followed by saturation to a signed W_DATA result.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module os_round_sat #(
  parameter int W_SUM  = 27,
  parameter int W_DATA = 18,
  parameter int W_OS   = 5
) (
  input  logic signed [W_SUM-1:0]  sum,
  input  logic        [W_OS-1:0]   os,
  output logic signed [W_DATA-1:0] result,
  output logic                     sat
);

  // Output range expressed at the one-bit-wider internal width
  localparam logic signed [W_SUM:0] C_MAX = {{(W_SUM-W_DATA+2){1'b0}}, {(W_DATA-1){1'b1}}};
  localparam logic signed [W_SUM:0] C_MIN = {{(W_SUM-W_DATA+2){1'b1}}, {(W_DATA-1){1'b0}}};

  logic signed [W_SUM:0] rnd;
  logic signed [W_SUM:0] t;
  logic signed [W_SUM:0] q;

  // Add half an LSB of the shifted result, shift arithmetically, then clamp
  always_comb begin
    rnd = '0;
    if (os != '0) rnd = (W_SUM+1)'(1) << (os - W_OS'(1));
    // One extra bit keeps sum + rnd from wrapping at the positive limit
    t = {sum[W_SUM-1], sum} + rnd;
    q = t >>> os;
    sat    = 1'b0;
    result = q[W_DATA-1:0];
    if (q > C_MAX) begin
      sat    = 1'b1;
      result = C_MAX[W_DATA-1:0];
    end else if (q < C_MIN) begin
      sat    = 1'b1;
      result = C_MIN[W_DATA-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/os_scale_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : os_scale_stage                                         |
// | Description : Post-oversample normalisation. Per channel: scale the  |
// |               accumulated sum by 2^-os with rounding, saturate, gate |
// |               by channel enable and keep sticky saturation flags.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module os_scale_stage
  import os_scale_stage_pkg::*;
#(
  parameter int W_CHAN    = 5,
  parameter int N_CHAN    = 20,
  parameter int W_DATA    = 18,
  parameter int W_SUM     = 27,
  parameter int W_OS      = 5,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 5,
  parameter int W_WR_DATA = 49
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     dv_in,
  input  logic [W_CHAN-1:0]        chan_in,
  input  logic signed [W_SUM-1:0]  sum_in,
  input  logic                     wr_en,
  input  logic [W_WR_ADDR-1:0]     wr_addr,
  input  logic [W_WR_CHAN-1:0]     wr_chan,
  input  logic [W_WR_DATA-1:0]     wr_data,
  output logic                     dv_out,
  output logic [W_CHAN-1:0]        chan_out,
  output logic signed [W_DATA-1:0] data_out,
  output logic [N_CHAN-1:0]        sat_out
);

  cfg_op_e           cfg_op;
  logic              wr_hit;
  logic [W_OS-1:0]   wr_os;

  // Per-channel config and status
  logic [W_OS-1:0]   os_mem_q [N_CHAN];
  logic [W_OS-1:0]   os_mem_d [N_CHAN];
  logic [N_CHAN-1:0] en_mem_q, en_mem_d;
  logic [N_CHAN-1:0] clr_rqst_q, clr_rqst_d;
  logic [N_CHAN-1:0] sat_q, sat_d;

  // P1 (fetch) registers
  logic              chan_ok;
  logic              dv_p1_q, dv_p1_d;
  logic [W_CHAN-1:0] chan_p1_q, chan_p1_d;
  logic signed [W_SUM-1:0] sum_p1_q, sum_p1_d;
  logic [W_OS-1:0]   os_p1_q, os_p1_d;
  logic              en_p1_q, en_p1_d;

  // P2 (scale) registers
  logic              dv_out_q, dv_out_d;
  logic [W_CHAN-1:0] chan_out_q, chan_out_d;
  logic signed [W_DATA-1:0] data_out_q, data_out_d;

  logic signed [W_DATA-1:0] rs_result;
  logic              rs_sat;

  // Decode the config bus; the shift clamp is applied here so stored values are always legal
  always_comb begin
    cfg_op = decode_cfg(32'(wr_addr));
    wr_hit = wr_en && (32'(wr_chan) < N_CHAN);
    wr_os  = (32'(wr_data[W_OS-1:0]) > 32'(W_SUM-1)) ? W_OS'(W_SUM-1) : wr_data[W_OS-1:0];
  end

  // Config memory updates; a clear request lives for exactly one cycle
  always_comb begin
    os_mem_d   = os_mem_q;
    en_mem_d   = en_mem_q;
    clr_rqst_d = '0;
    if (wr_hit) begin
      case (cfg_op)
        CFG_OS:  os_mem_d[wr_chan]   = wr_os;
        CFG_EN:  en_mem_d[wr_chan]   = wr_data[0];
        CFG_CLR: clr_rqst_d[wr_chan] = 1'b1;
        default: ;
      endcase
    end
  end

  // P1 fetch: reads registered config, so a same-cycle write is seen only by later samples
  always_comb begin
    chan_ok   = 32'(chan_in) < N_CHAN;
    dv_p1_d   = dv_in && chan_ok && !clr_rqst_q[chan_in];
    chan_p1_d = chan_in;
    sum_p1_d  = sum_in;
    os_p1_d   = chan_ok ? os_mem_q[chan_in] : '0;
    en_p1_d   = chan_ok && en_mem_q[chan_in];
  end

  os_round_sat #(
    .W_SUM  (W_SUM),
    .W_DATA (W_DATA),
    .W_OS   (W_OS)
  ) u_round_sat (
    .sum    (sum_p1_q),
    .os     (os_p1_q),
    .result (rs_result),
    .sat    (rs_sat)
  );

  // P2 scale: emit enabled samples not hit by a clear; data holds between valid outputs
  always_comb begin
    dv_out_d   = dv_p1_q && en_p1_q && !clr_rqst_q[chan_p1_q];
    chan_out_d = chan_p1_q;
    data_out_d = dv_out_d ? rs_result : data_out_q;
  end

  // Sticky saturation flags; a clear overrides a same-cycle saturation
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      if (clr_rqst_q[i])
        sat_d[i] = 1'b0;
      else if (dv_out_d && rs_sat && (32'(chan_p1_q) == i))
        sat_d[i] = 1'b1;
      else
        sat_d[i] = sat_q[i];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < N_CHAN; i++) os_mem_q[i] <= W_OS'(OSC_OS_INIT);
      en_mem_q   <= {N_CHAN{OSC_EN_INIT[0]}};
      clr_rqst_q <= '0;
      sat_q      <= '0;
      dv_p1_q    <= 1'b0;
      chan_p1_q  <= '0;
      sum_p1_q   <= '0;
      os_p1_q    <= '0;
      en_p1_q    <= 1'b0;
      dv_out_q   <= 1'b0;
      chan_out_q <= '0;
      data_out_q <= '0;
    end else begin
      os_mem_q   <= os_mem_d;
      en_mem_q   <= en_mem_d;
      clr_rqst_q <= clr_rqst_d;
      sat_q      <= sat_d;
      dv_p1_q    <= dv_p1_d;
      chan_p1_q  <= chan_p1_d;
      sum_p1_q   <= sum_p1_d;
      os_p1_q    <= os_p1_d;
      en_p1_q    <= en_p1_d;
      dv_out_q   <= dv_out_d;
      chan_out_q <= chan_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign dv_out   = dv_out_q;
  assign chan_out = chan_out_q;
  assign data_out = data_out_q;
  assign sat_out  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_os_scale_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_os_scale_stage                                      |
// | Description : Scoreboard bench for os_scale_stage: directed samples  |
// |               push expected outputs, a monitor pops and compares.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_os_scale_stage;
  import os_scale_stage_pkg::*;

  localparam int W_CHAN    = 5;
  localparam int N_CHAN    = 20;
  localparam int W_DATA    = 18;
  localparam int W_SUM     = 27;
  localparam int W_OS      = 5;
  localparam int W_WR_ADDR = 16;
  localparam int W_WR_CHAN = 5;
  localparam int W_WR_DATA = 49;

  logic                     clk_in = 1'b0;
  logic                     rst_in = 1'b0;
  logic                     dv_in = 1'b0;
  logic [W_CHAN-1:0]        chan_in = '0;
  logic signed [W_SUM-1:0]  sum_in = '0;
  logic                     wr_en = 1'b0;
  logic [W_WR_ADDR-1:0]     wr_addr = '0;
  logic [W_WR_CHAN-1:0]     wr_chan = '0;
  logic [W_WR_DATA-1:0]     wr_data = '0;
  logic                     dv_out;
  logic [W_CHAN-1:0]        chan_out;
  logic signed [W_DATA-1:0] data_out;
  logic [N_CHAN-1:0]        sat_out;

  os_scale_stage dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .dv_in    (dv_in),
    .chan_in  (chan_in),
    .sum_in   (sum_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .dv_out   (dv_out),
    .chan_out (chan_out),
    .data_out (data_out),
    .sat_out  (sat_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int data;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every valid output must match the oldest outstanding expectation
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in && dv_out) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got chan %0d data %0d, expected no output",
                 chan_out, $signed(data_out));
      end else begin
        e = exp_q.pop_front();
        check("out_chan", int'(chan_out), e.ch);
        check("out_data", int'(data_out), e.data);
        check("out_latency", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input int addr, input int ch, input int d);
    wr_en   = 1'b1;
    wr_addr = W_WR_ADDR'(addr);
    wr_chan = W_WR_CHAN'(ch);
    wr_data = W_WR_DATA'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push(input int ch, input int d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    e.due  = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic send(input int ch, input int s, input bit expect_out, input int d);
    dv_in   = 1'b1;
    chan_in = W_CHAN'(ch);
    sum_in  = W_SUM'(s);
    if (expect_out) push(ch, d);
    tick();
    dv_in   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_dv_out", int'(dv_out), 0);
    check("rst_chan_out", int'(chan_out), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_sat_out", int'(sat_out), 0);
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b1;
    tick();

    // T1: os=3 rounding, positive and negative
    wr(OSC_OS_ADDR, 0, 3);
    send(0, 100, 1, 13);
    send(0, -100, 1, -12);
    drain();
    check("t1_sat0", int'(sat_out[0]), 0);

    // T2: os=0 saturation both ways, sticky flag
    wr(OSC_OS_ADDR, 1, 0);
    send(1, 200000, 1, 131071);
    send(1, -200000, 1, -131072);
    drain();
    check("t2_sat1", int'(sat_out[1]), 1);

    // T3: os write of 31 clamps to 26
    wr(OSC_OS_ADDR, 2, 31);
    send(2, 33554432, 1, 1);
    send(2, 33554431, 1, 0);
    drain();
    check("t3_sat2", int'(sat_out[2]), 0);

    // T4: ch4 disabled, interleaved with ch5, then back-to-back ch5
    wr(OSC_EN_ADDR, 4, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send(4, 200000, 0, 0);
      else            send(5, i * 1000, 1, i * 1000);
    end
    send(5, 7000, 1, 7000);
    send(5, -9000, 1, -9000);
    send(4, 200000, 0, 0);
    drain();
    check("t4_hold_data", int'(data_out), -9000);
    check("t4_sat4", int'(sat_out[4]), 0);

    // T5: saturate ch2, then clear it while ch2 sits in P1 and ch3 is ahead
    wr(OSC_OS_ADDR, 2, 0);
    send(2, 200000, 1, 131071);
    drain();
    check("t5_sat2_set", int'(sat_out[2]), 1);
    dv_in = 1'b1; chan_in = 5'd3; sum_in = W_SUM'(500);
    push(3, 500);
    tick();
    chan_in = 5'd2; sum_in = W_SUM'(200000);
    wr_en = 1'b1; wr_addr = W_WR_ADDR'(OSC_CLR_RQST); wr_chan = 5'd2; wr_data = '0;
    tick();
    dv_in = 1'b0; wr_en = 1'b0;
    drain();
    check("t5_sat2_clr", int'(sat_out[2]), 0);
    check("t5_sat1_kept", int'(sat_out[1]), 1);

    // T6: async reset while a sample is on the output
    send(5, 11, 1, 11);
    send(5, 22, 0, 0);
    tick();
    check("t6_pre_dv", int'(dv_out), 1);
    rst_in = 1'b0;
    #1;
    check("t6_async_dv", int'(dv_out), 0);
    check("t6_async_data", int'(data_out), 0);
    check("t6_async_sat", int'(sat_out), 0);
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b1;
    tick();
    wr(OSC_OS_ADDR, 25, 3);
    wr(OSC_EN_ADDR, 25, 0);
    send(0, 100, 1, 100);
    send(4, 77, 1, 77);
    send(5, 100, 1, 100);
    send(9, 100, 1, 100);
    send(1, 200000, 1, 131071);
    drain();
    check("t6_sat1", int'(sat_out[1]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
